pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 255, bus-hold cycles before a timeout pulse (1..255).
REQ-002 SHALL have parameter WDOG_W, default 8, watchdog counter width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ex_jump_req_i  input  1  execute-stage branch/jump request.
REQ-006 ex_jump_addr_i  input  32  execute-stage target.
REQ-007 int_jump_req_i  input  1  interrupt/trap-entry redirect request.
REQ-008 int_jump_addr_i  input  32  trap-vector target.
REQ-009 ex_hold_req_i  input  1  multi-cycle execute op in progress.
REQ-010 bus_hold_req_i  input  1  bus busy, fetch must stall.
REQ-011 dbg_halt_req_i  input  1  debug halt request, level.
REQ-012 jump_flag_o  output  1  PC redirect enable.
REQ-013 jump_addr_o  output  32  PC redirect target.
REQ-014 hold_flag_o  output  3  pipeline hold level: 0 none, 1 PC, 2 IF, 3 ID.
REQ-015 dbg_halt_ack_o  output  1  core halted.
REQ-016 bus_timeout_o  output  1  one-cycle watchdog pulse.

Function
REQ-017 jump_flag_o/jump_addr_o SHALL be combinational, same-cycle; int_jump_req_i wins over ex_jump_req_i.
REQ-018 int_jump_req_i SHALL be masked while the FSM is HALTED; ex_jump_req_i is never masked.
REQ-019 With no jump winner, jump_flag_o=0 and jump_addr_o=0.
REQ-020 hold_flag_o SHALL be combinational: 3 if jump_flag_o, ex_hold_req_i, or FSM=HALTED; else 1 if bus_hold_req_i or FSM=HALT_WAIT; else 0.
REQ-021 Halt FSM states SHALL be RUN, HALT_WAIT, HALTED (2-bit register).
REQ-022 RUN -> HALT_WAIT when dbg_halt_req_i=1.
REQ-023 HALT_WAIT -> HALTED when dbg_halt_req_i=1 and ex_hold_req_i=0, bus_hold_req_i=0, and jump_flag_o=0 in the same cycle; otherwise stays in HALT_WAIT.
REQ-024 HALT_WAIT -> RUN when dbg_halt_req_i=0; this takes priority over REQ-023.
REQ-025 HALTED -> RUN when dbg_halt_req_i=0; otherwise stays in HALTED.
REQ-026 dbg_halt_ack_o SHALL be 1 exactly while the FSM is HALTED (decoded from the state register, no combinational input path).
REQ-027 Watchdog counter SHALL increment each cycle bus_hold_req_i=1 and clear when bus_hold_req_i=0.
REQ-028 When the counter equals WDOG_LIMIT-1 and bus_hold_req_i=1, bus_timeout_o SHALL be 1 for the next cycle (registered) and the counter clears to 0; it then keeps counting, so pulses repeat every WDOG_LIMIT cycles.
REQ-029 Watchdog SHALL NOT affect hold_flag_o or jump outputs.

Reset
REQ-030 On rst=1, the FSM SHALL go to RUN, the counter to 0, and dbg_halt_ack_o=0 and bus_timeout_o=0, asynchronously.
REQ-031 During reset, combinational outputs SHALL still follow REQ-017..020 with FSM=RUN.
REQ-032 Reset asserted mid-halt or mid-count SHALL abandon the halt and clear the count, with no pulse afterward.

Configuration
REQ-033 Macro PIPE_CTRL_WDOG_EN: defined -> watchdog per REQ-027..028; undefined -> no counter, bus_timeout_o tied 0, WDOG_* parameters unused.

Verification
REQ-034 ex_jump_req_i=1, addr 0x0000_0100, same cycle int_jump_req_i=1, addr 0x0000_0004 -> jump_flag_o=1, jump_addr_o=0x4, hold_flag_o=3.
REQ-035 bus_hold_req_i=1 alone -> hold_flag_o=1; add ex_hold_req_i=1 -> hold_flag_o=3; both drop -> hold_flag_o=0.
REQ-036 dbg_halt_req_i=1 while bus_hold_req_i=1 for 3 cycles -> HALT_WAIT with hold_flag_o=1; dbg_halt_ack_o rises 1 cycle after bus_hold_req_i falls; then hold_flag_o=3.
REQ-037 While HALTED, int_jump_req_i=1 -> jump_flag_o=0; drop dbg_halt_req_i -> ack falls next edge, and the next int_jump passes through.
REQ-038 With WDOG_LIMIT=4 and macro defined, hold bus_hold_req_i=1 for 10 cycles -> bus_timeout_o pulses in cycles 5 and 9; with macro undefined -> stays 0.
REQ-039 Assert rst mid-HALTED with counter at 2 -> ack=0 and counter=0 immediately, no pulse after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: PC redirect arbitration, hold-level generation, debug halt FSM
// and an optional bus-hold watchdog enabled by the PIPE_CTRL_WDOG_EN macro.
module pipe_ctrl #(
  parameter int WDOG_LIMIT = 255,
  parameter int WDOG_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_req_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        int_jump_req_i,
  input  logic [31:0] int_jump_addr_i,
  input  logic        ex_hold_req_i,
  input  logic        bus_hold_req_i,
  input  logic        dbg_halt_req_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o,
  output logic        dbg_halt_ack_o,
  output logic        bus_timeout_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_WAIT = 2'd1,
    HALTED    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        int_jump_s;
  logic        jump_flag_s;
  logic [31:0] jump_addr_s;
  logic [2:0]  hold_flag_s;

  // Trap entry cannot redirect a halted core; execute redirects always can.
  assign int_jump_s = int_jump_req_i && (state_q != HALTED);

  always_comb begin
    jump_flag_s = 1'b0;
    jump_addr_s = 32'h0000_0000;
    if (int_jump_s) begin
      jump_flag_s = 1'b1;
      jump_addr_s = int_jump_addr_i;
    end else if (ex_jump_req_i) begin
      jump_flag_s = 1'b1;
      jump_addr_s = ex_jump_addr_i;
    end else begin
      jump_flag_s = 1'b0;
      jump_addr_s = 32'h0000_0000;
    end
  end

  always_comb begin
    hold_flag_s = 3'd0;
    if (jump_flag_s || ex_hold_req_i || (state_q == HALTED)) begin
      hold_flag_s = 3'd3;
    end else if (bus_hold_req_i || (state_q == HALT_WAIT)) begin
      hold_flag_s = 3'd1;
    end else begin
      hold_flag_s = 3'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dbg_halt_req_i) state_d = HALT_WAIT;
        else                state_d = RUN;
      end
      HALT_WAIT: begin
        // Dropping the request abandons the halt even if the pipeline is quiet.
        if (!dbg_halt_req_i) begin
          state_d = RUN;
        end else if (!ex_hold_req_i && !bus_hold_req_i && !jump_flag_s) begin
          state_d = HALTED;
        end else begin
          state_d = HALT_WAIT;
        end
      end
      HALTED: begin
        if (!dbg_halt_req_i) state_d = RUN;
        else                 state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  // Counter restarts after each pulse so a stuck bus keeps reporting.
  always_comb begin
    cnt_d     = {WDOG_W{1'b0}};
    timeout_d = 1'b0;
    if (bus_hold_req_i) begin
      if (cnt_q == WDOG_LAST) begin
        cnt_d     = {WDOG_W{1'b0}};
        timeout_d = 1'b1;
      end else begin
        cnt_d     = cnt_q + WDOG_ONE;
        timeout_d = 1'b0;
      end
    end else begin
      cnt_d     = {WDOG_W{1'b0}};
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= {WDOG_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_timeout_o = timeout_q;
`else
  logic [WDOG_W-1:0] unused_wdog_s;
  assign unused_wdog_s = WDOG_W'(WDOG_LIMIT);
  assign bus_timeout_o = 1'b0;
`endif

  assign jump_flag_o    = jump_flag_s;
  assign jump_addr_o    = jump_addr_s;
  assign hold_flag_o    = hold_flag_s;
  assign dbg_halt_ack_o = (state_q == HALTED);

endmodule
